// File: rtl/mw_pkg.sv
//------------------------------------------------------------------------------
// mw_pkg : shared types and helpers for the microwave control stage
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mw_pkg;

    localparam int DIGIT_W   = 4;
    localparam int KEY_COUNT = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Returns the index of the highest set key; callers qualify with a one-hot test.
    function automatic logic [DIGIT_W-1:0] key_encode(input logic [KEY_COUNT-1:0] keys);
        logic [DIGIT_W-1:0] digit;
        digit = '0;
        for (int i = 0; i < KEY_COUNT; i++) begin
            if (keys[i]) begin
                digit = DIGIT_W'(i);
            end
        end
        return digit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mw_debounce.sv
//------------------------------------------------------------------------------
// mw_debounce : 2-FF synchroniser plus stable-sample debouncer with edge pulses
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mw_debounce #(
    parameter int   DEB_CYCLES  = 4,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic clrn,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int                C_CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEB_CYCLES - 1);

    logic [1:0]         r_sync;
    logic [C_CNT_W-1:0] r_cnt;

    // r_cnt counts consecutive synchronised samples that disagree with level;
    // the edge pulses are registered alongside the level change itself.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_sync <= {2{RESET_LEVEL}};
            r_cnt  <= '0;
            level  <= RESET_LEVEL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], raw};
            rise   <= 1'b0;
            fall   <= 1'b0;
            if (r_sync[1] == level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
                r_cnt <= '0;
                level <= r_sync[1];
                rise  <= r_sync[1];
                fall  <= ~r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mw_control.sv
//------------------------------------------------------------------------------
// mw_control : input conditioning, keypad load, 1 Hz tick and cook FSM
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mw_control
    import mw_pkg::*;
#(
    parameter int TICK_DIV   = 100,
    parameter int DEB_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic [KEY_COUNT-1:0] keypad,
    input  logic                 startn,
    input  logic                 stopn,
    input  logic                 door_closed,
    input  logic                 timer_zero,
    output logic [DIGIT_W-1:0]   data,
    output logic                 loadn,
    output logic                 timer_clrn,
    output logic                 en,
    output logic                 mag_on,
    output logic                 done
);

    localparam int                  C_PRESC_W    = $clog2(TICK_DIV);
    localparam logic [C_PRESC_W-1:0] C_PRESC_LAST = C_PRESC_W'(TICK_DIV - 1);

    logic [KEY_COUNT-1:0] w_key_level;
    logic [KEY_COUNT-1:0] w_key_rise;
    logic [KEY_COUNT-1:0] w_unused_key_fall;
    logic                 w_start_evt;
    logic                 w_unused_start_level;
    logic                 w_unused_start_rise;
    logic                 w_stop_evt;
    logic                 w_unused_stop_level;
    logic                 w_unused_stop_rise;
    logic                 w_door_closed;
    logic                 w_unused_door_rise;
    logic                 w_unused_door_fall;

    generate
        for (genvar gi = 0; gi < KEY_COUNT; gi++) begin : g_key_deb
            mw_debounce #(
                .DEB_CYCLES  (DEB_CYCLES),
                .RESET_LEVEL (1'b0)
            ) u_key_deb (
                .clk   (clk),
                .clrn  (clrn),
                .raw   (keypad[gi]),
                .level (w_key_level[gi]),
                .rise  (w_key_rise[gi]),
                .fall  (w_unused_key_fall[gi])
            );
        end
    endgenerate

    // Buttons are active low, so a press is the falling edge of the debounced level.
    mw_debounce #(
        .DEB_CYCLES  (DEB_CYCLES),
        .RESET_LEVEL (1'b1)
    ) u_start_deb (
        .clk   (clk),
        .clrn  (clrn),
        .raw   (startn),
        .level (w_unused_start_level),
        .rise  (w_unused_start_rise),
        .fall  (w_start_evt)
    );

    mw_debounce #(
        .DEB_CYCLES  (DEB_CYCLES),
        .RESET_LEVEL (1'b1)
    ) u_stop_deb (
        .clk   (clk),
        .clrn  (clrn),
        .raw   (stopn),
        .level (w_unused_stop_level),
        .rise  (w_unused_stop_rise),
        .fall  (w_stop_evt)
    );

    mw_debounce #(
        .DEB_CYCLES  (DEB_CYCLES),
        .RESET_LEVEL (1'b0)
    ) u_door_deb (
        .clk   (clk),
        .clrn  (clrn),
        .raw   (door_closed),
        .level (w_door_closed),
        .rise  (w_unused_door_rise),
        .fall  (w_unused_door_fall)
    );

    logic               w_key_evt;
    logic               w_key_valid;
    logic [DIGIT_W-1:0] w_digit;
    logic               w_tick;

    assign w_key_evt   = |w_key_rise;
    assign w_key_valid = w_key_evt && $onehot(w_key_level);
    assign w_digit     = key_encode(w_key_level);

    state_t               r_state;
    logic [C_PRESC_W-1:0] r_presc;

    assign w_tick = (r_presc == C_PRESC_LAST);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state    <= IDLE;
            r_presc    <= '0;
            data       <= '0;
            loadn      <= 1'b1;
            timer_clrn <= 1'b0;
            en         <= 1'b0;
            mag_on     <= 1'b0;
            done       <= 1'b0;
        end else begin
            loadn      <= 1'b1;
            timer_clrn <= 1'b1;
            en         <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_stop_evt) begin
                        timer_clrn <= 1'b0;
                    end else if (w_start_evt && w_door_closed && !timer_zero) begin
                        r_state <= COOK;
                        r_presc <= '0;
                        mag_on  <= 1'b1;
                    end
                    if (w_key_valid) begin
                        data  <= w_digit;
                        loadn <= 1'b0;
                    end
                end
                COOK: begin
                    // Leaving COOK freezes the prescaler so PAUSE can resume mid-second.
                    if (timer_zero) begin
                        r_state <= DONE;
                        mag_on  <= 1'b0;
                        done    <= 1'b1;
                    end else if (!w_door_closed || w_stop_evt) begin
                        r_state <= PAUSE;
                        mag_on  <= 1'b0;
                    end else if (w_tick) begin
                        r_presc <= '0;
                        en      <= 1'b1;
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                PAUSE: begin
                    if (w_stop_evt) begin
                        r_state    <= IDLE;
                        timer_clrn <= 1'b0;
                    end else if (w_start_evt && w_door_closed) begin
                        r_state <= COOK;
                        mag_on  <= 1'b1;
                    end
                end
                DONE: begin
                    if (w_key_evt || w_start_evt || w_stop_evt || !w_door_closed) begin
                        r_state <= IDLE;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    mag_on  <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
